monitor_sensores: RTL and testbench
===================================

MONITOR_SENSORES -- requirements
Module: monitor_sensores

Interface
REQ-001 Parameter N_SENS, default 3: number of sensor inputs, 1..8.
REQ-002 Parameter TIMEOUT_CYC, default 8: consecutive cycles an error may persist before sensor fault, >=2.
REQ-003 Parameter CODE_BASE, default 5: display code of sensor 0; CODE_BASE+N_SENS-1 <= 14.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 START  input  1  request a sensor analysis.
REQ-007 ACK  input  1  operator acknowledge; returns block to idle.
REQ-008 SENS  input  N_SENS  error condition per sensor, 1 = error; index 0 = highest priority.
REQ-009 SAIDA  output  2  status: 00 idle/analysis, 01 error pending, 10 no errors, 11 sensor fault.
REQ-010 SAIDA_DISPLAY  output  4  display code of active/failed sensor, 0 otherwise.
REQ-011 ERR_IDX  output  3  index of active/failed sensor, 0 otherwise.
REQ-012 FALHAS  output  8  saturating count of entries into FALHA.

Function
REQ-013 States: IDLE, ANALISE, ERRO, SEM_ERROS, FALHA; outputs decoded from registered state, idx, counter only (Moore, no combinational input-to-output path).
REQ-014 IDLE: SAIDA=00, display 0; START -> ANALISE; else stay.
REQ-015 ANALISE (exactly one cycle, SAIDA=00): any SENS bit set -> ERRO with idx = lowest set index, timer=0; none set -> SEM_ERROS.
REQ-016 ERRO: SAIDA=01, SAIDA_DISPLAY=CODE_BASE+idx, ERR_IDX=idx.
REQ-017 ERRO each cycle, s = lowest set SENS index: no bit set -> SEM_ERROS; s != idx -> idx=s, timer=0 (priority re-evaluated every cycle, higher-priority arrival preempts); s == idx and timer==TIMEOUT_CYC-1 -> FALHA; else timer+1.
REQ-018 With SENS constant and nonzero, FALHA entered exactly TIMEOUT_CYC edges after edge entering ERRO.
REQ-019 Timer width $clog2(TIMEOUT_CYC); never wraps, since FALHA or reload occurs at TIMEOUT_CYC-1.
REQ-020 FALHA: SAIDA=11, display/ERR_IDX hold failing sensor; START ignored; ACK -> IDLE; latched regardless of SENS.
REQ-021 SEM_ERROS: SAIDA=10, display 0; ACK -> IDLE; START -> ANALISE; START and ACK together -> IDLE (ACK wins).
REQ-022 ACK ignored in IDLE, ANALISE, ERRO.
REQ-023 FALHAS increments on each ERRO->FALHA edge, saturates at 255, cleared only by reset.

Reset
REQ-024 RST_N low asynchronously forces IDLE, idx=0, timer=0, FALHAS=0, SAIDA=00, SAIDA_DISPLAY=0, ERR_IDX=0.
REQ-025 Reset asserted mid-operation (any state, including FALHA) aborts immediately; no state retained.
REQ-026 After RST_N deasserts, first state change no earlier than the next rising CLK edge.

Configuration
REQ-027 Macro MONITOR_SENSORES_SYNC_EN defined: SENS passes through a 2-flop synchronizer (reset to 0) before all use; sensor-to-decision latency +2 cycles.
REQ-028 Macro undefined: SENS used directly; all timing as in REQ-013..REQ-023.

Verification (N_SENS=3, TIMEOUT_CYC=8, CODE_BASE=5, macro undefined)
REQ-029 SENS=000, START pulse -> SAIDA 00 for one cycle (ANALISE), then 10, display 0; ACK -> SAIDA 00.
REQ-030 SENS=010 held, START -> SAIDA=01, display 6, ERR_IDX=1; exactly 8 cycles later SAIDA=11, FALHAS=1; ACK -> IDLE.
REQ-031 SENS=100 held, START; after 4 cycles in ERRO set SENS=101 -> display 5, timer restarts, FALHA after 8 further cycles with display 5.
REQ-032 SENS=010, START; after 3 cycles in ERRO set SENS=000 -> SAIDA=10 next edge, FALHAS unchanged.
REQ-033 In FALHA assert RST_N=0 between clock edges -> all outputs 0 immediately; in SEM_ERROS with START=ACK=1 -> IDLE.

Source files
------------

// File: rtl/monitor_sensores.sv
// monitor_sensores: prioritised sensor-error monitor with per-sensor fault timeout.
//
// A START request runs a one-cycle analysis of SENS. If any sensor reports an error, the
// block reports the highest-priority one, with index 0 as the highest priority. The block
// re-evaluates priority on every cycle. If the same sensor stays in error for TIMEOUT_CYC
// consecutive cycles, the block latches a sensor fault until ACK. All outputs are decoded
// from registered state only.
//
// Optional feature: define MONITOR_SENSORES_SYNC_EN to pass SENS through a 2-flop
// synchronizer before use. This adds two cycles of sensor-to-decision latency.
//
// Ports:
//   CLK            clock, rising edge
//   RST_N          asynchronous active-low reset
//   START          request a sensor analysis
//   ACK            operator acknowledge (from SEM_ERROS / FALHA back to idle)
//   SENS           per-sensor error flags, 1 = error, index 0 = highest priority
//   SAIDA          status: 00 idle/analysis, 01 error pending, 10 no errors, 11 sensor fault
//   SAIDA_DISPLAY  CODE_BASE + index of the active/failed sensor, 0 otherwise
//   ERR_IDX        index of the active/failed sensor, 0 otherwise
//   FALHAS         saturating count of fault entries, cleared only by reset
module monitor_sensores #(
    parameter int unsigned N_SENS      = 3,
    parameter int unsigned TIMEOUT_CYC = 8,
    parameter int unsigned CODE_BASE   = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ACK,
    input  logic [N_SENS-1:0] SENS,
    output logic [1:0]        SAIDA,
    output logic [3:0]        SAIDA_DISPLAY,
    output logic [2:0]        ERR_IDX,
    output logic [7:0]        FALHAS
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAnalise,
        StErro,
        StSemErros,
        StFalha
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      falhas_q, falhas_d;

    logic [N_SENS-1:0] sens_use;
    logic              sens_any;
    logic [2:0]        sens_low;

`ifdef MONITOR_SENSORES_SYNC_EN
    logic [N_SENS-1:0] sens_meta_q, sens_sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sens_meta_q <= '0;
            sens_sync_q <= '0;
        end else begin
            sens_meta_q <= SENS;
            sens_sync_q <= sens_meta_q;
        end
    end

    assign sens_use = sens_sync_q;
`else
    assign sens_use = SENS;
`endif

    // Lowest set index wins. The descending scan leaves the lowest index assigned last.
    always_comb begin
        sens_any = |sens_use;
        sens_low = '0;
        for (int i = int'(N_SENS) - 1; i >= 0; i--) begin
            if (sens_use[i]) begin
                sens_low = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            timer_q  <= '0;
            falhas_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            falhas_q <= falhas_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        falhas_d = falhas_q;
        unique case (state_q)
            StIdle: begin
                if (START) state_d = StAnalise;
            end
            StAnalise: begin
                if (sens_any) begin
                    state_d = StErro;
                    idx_d   = sens_low;
                    timer_d = '0;
                end else begin
                    state_d = StSemErros;
                end
            end
            StErro: begin
                if (!sens_any) begin
                    state_d = StSemErros;
                end else if (sens_low != idx_q) begin
                    // A different sensor now has priority, so its timeout starts from zero.
                    idx_d   = sens_low;
                    timer_d = '0;
                end else if (timer_q == TimerLast) begin
                    state_d = StFalha;
                    if (falhas_q != 8'hFF) falhas_d = falhas_q + 8'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StSemErros: begin
                if (ACK) begin
                    state_d = StIdle;
                end else if (START) begin
                    state_d = StAnalise;
                end
            end
            StFalha: begin
                if (ACK) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        SAIDA         = 2'b00;
        SAIDA_DISPLAY = 4'd0;
        ERR_IDX       = 3'd0;
        unique case (state_q)
            StErro: begin
                SAIDA         = 2'b01;
                SAIDA_DISPLAY = 4'(CODE_BASE) + {1'b0, idx_q};
                ERR_IDX       = idx_q;
            end
            StFalha: begin
                SAIDA         = 2'b11;
                SAIDA_DISPLAY = 4'(CODE_BASE) + {1'b0, idx_q};
                ERR_IDX       = idx_q;
            end
            StSemErros: SAIDA = 2'b10;
            default: ;
        endcase
        FALHAS = falhas_q;
    end

endmodule

// File: tb/tb_monitor_sensores.sv
// Self-checking bench for monitor_sensores (N_SENS=3, TIMEOUT_CYC=8, CODE_BASE=5).
module tb_monitor_sensores;

    localparam int N  = 3;
    localparam int T  = 8;
    localparam int CB = 5;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         ACK   = 1'b0;
    logic [N-1:0] SENS  = '0;
    logic [1:0]   SAIDA;
    logic [3:0]   SAIDA_DISPLAY;
    logic [2:0]   ERR_IDX;
    logic [7:0]   FALHAS;

    monitor_sensores #(
        .N_SENS      (N),
        .TIMEOUT_CYC (T),
        .CODE_BASE   (CB)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .START         (START),
        .ACK           (ACK),
        .SENS          (SENS),
        .SAIDA         (SAIDA),
        .SAIDA_DISPLAY (SAIDA_DISPLAY),
        .ERR_IDX       (ERR_IDX),
        .FALHAS        (FALHAS)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int s, input int d, input int e,
                           input int f);
        chk({name, ".saida"},   int'(SAIDA),         s);
        chk({name, ".display"}, int'(SAIDA_DISPLAY), d);
        chk({name, ".err_idx"}, int'(ERR_IDX),       e);
        chk({name, ".falhas"},  int'(FALHAS),        f);
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_ANALISE = 1, M_ERRO = 2, M_SEM = 3, M_FALHA = 4;
    int m_mode, m_sensor, m_age, m_faults;

    task automatic model_reset();
        m_mode = M_IDLE; m_sensor = 0; m_age = 0; m_faults = 0;
    endtask

    function automatic int lowest_set(input logic [N-1:0] s);
        int r = -1;
        for (int b = 0; b < N; b++) if (r < 0 && s[b]) r = b;
        return r;
    endfunction

    // m_age = edges the current sensor has been continuously active.
    task automatic model_step(input logic st, input logic ak, input logic [N-1:0] s);
        int low = lowest_set(s);
        case (m_mode)
            M_IDLE:    if (st) m_mode = M_ANALISE;
            M_ANALISE: begin
                if (low >= 0) begin m_mode = M_ERRO; m_sensor = low; m_age = 0; end
                else m_mode = M_SEM;
            end
            M_ERRO: begin
                if (low < 0) m_mode = M_SEM;
                else if (low != m_sensor) begin m_sensor = low; m_age = 0; end
                else if (m_age + 1 == T) begin
                    m_mode = M_FALHA;
                    m_faults = (m_faults >= 255) ? 255 : m_faults + 1;
                end else m_age++;
            end
            M_SEM:   if (ak) m_mode = M_IDLE; else if (st) m_mode = M_ANALISE;
            default: if (ak) m_mode = M_IDLE;
        endcase
    endtask

    function automatic int m_saida();
        case (m_mode)
            M_ERRO:  return 1;
            M_SEM:   return 2;
            M_FALHA: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_shows();
        return (m_mode == M_ERRO) || (m_mode == M_FALHA);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       start;
        logic       ack;
        logic [2:0] sens;
        int         saida;
        int         disp;
        int         idx;
        int         falhas;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic ak, input logic [2:0] s,
                                input int sa, input int d, input int e, input int f);
        vec_t v;
        v.start = st; v.ack = ak; v.sens = s;
        v.saida = sa; v.disp = d; v.idx = e; v.falhas = f;
        return v;
    endfunction

    logic [N-1:0] rs;
    logic         rst_start, rst_ack;

    initial begin
        // No-error analysis, then acknowledge
        tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'b000, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'b000, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0));
        // Sensor 1 held: ERRO for 8 edges, then FALHA
        tbl.push_back(mk(1, 0, 3'b010, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 3'b010, 1, 6, 1, 0));
        tbl.push_back(mk(0, 0, 3'b010, 3, 6, 1, 1));
        tbl.push_back(mk(1, 0, 3'b000, 3, 6, 1, 1));   // START ignored, SENS irrelevant
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1));   // ACK ignored in IDLE
        tbl.push_back(mk(1, 1, 3'b100, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'b100, 1, 7, 2, 1));   // ACK ignored in ANALISE
        tbl.push_back(mk(0, 1, 3'b100, 1, 7, 2, 1));   // ACK ignored in ERRO
        tbl.push_back(mk(0, 0, 3'b000, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'b000, 0, 0, 0, 1));   // ACK wins over START
        tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'b000, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 1));   // SEM_ERROS + START -> ANALISE
        tbl.push_back(mk(0, 0, 3'b000, 2, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1));

        // Reset state
        #12;
        chk_out("reset", 0, 0, 0, 0);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            START = tbl[i].start; ACK = tbl[i].ack; SENS = tbl[i].sens;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].saida, tbl[i].disp, tbl[i].idx,
                    tbl[i].falhas);
        end
        START = 0; ACK = 0;

        // Preemption by a higher-priority sensor restarts the timeout
        SENS = 3'b100; START = 1; step();
        START = 0; step();
        chk_out("pre.entry", 1, 7, 2, 1);
        repeat (3) step();
        SENS = 3'b101; step();
        chk_out("pre.switch", 1, 5, 0, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("pre.wait%0d", k), int'(SAIDA), 1);
        end
        step();
        chk_out("pre.falha", 3, 5, 0, 2);
        ACK = 1; step(); ACK = 0;

        // Error clears before the timeout
        SENS = 3'b010; START = 1; step();
        START = 0; repeat (3) step();
        SENS = 3'b000; step();
        chk_out("clear", 2, 0, 0, 2);
        ACK = 1; step(); ACK = 0;

        // Asynchronous reset in FALHA
        SENS = 3'b001; START = 1; step();
        START = 0; repeat (9) step();
        chk_out("f2", 3, 5, 0, 3);
        #3 RST_N = 0;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        SENS = 3'b010; START = 1;
        step();
        chk_out("rst_held", 0, 0, 0, 0);
        #2 RST_N = 1;
        #1 chk_out("rst_release", 0, 0, 0, 0);
        step();                                   // IDLE -> ANALISE on the first edge
        START = 0; step();
        chk_out("post_rst", 1, 6, 1, 0);
        SENS = 3'b000; step();
        chk_out("post_sem", 2, 0, 0, 0);
        START = 1; ACK = 1; step();
        START = 0; ACK = 0; step();
        chk_out("ack_wins", 0, 0, 0, 0);

        // FALHAS saturates at 255
        for (int i = 0; i < 258; i++) begin
            SENS = 3'b001; START = 1; step();
            START = 0; repeat (9) step();
            if (i == 0)   chk("sat.first", int'(FALHAS), 1);
            if (i == 254) chk("sat.255", int'(FALHAS), 255);
            ACK = 1; step(); ACK = 0;
        end
        chk("sat.hold", int'(FALHAS), 255);

        // Randomised run against the reference model
        RST_N = 0; #2; RST_N = 1;
        model_reset();
        rs = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                rs = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 7));
            end
            rst_start = ($urandom_range(0, 3) == 0);
            rst_ack   = ($urandom_range(0, 7) == 0);
            START = rst_start; ACK = rst_ack; SENS = rs;
            model_step(rst_start, rst_ack, rs);
            step();
            chk_out($sformatf("rnd%0d", c), m_saida(),
                    m_shows() ? CB + m_sensor : 0,
                    m_shows() ? m_sensor : 0, m_faults);
            if ($urandom_range(0, 299) == 0) begin
                RST_N = 0;
                #1;
                model_reset();
                chk_out($sformatf("rnd_rst%0d", c), 0, 0, 0, 0);
                RST_N = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
